// File: rtl/wave_capture_if.sv
// rtl/wave_capture_if.sv - sample stream, display status and RAM write bundle for wave_capture
interface wave_capture_if;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic        wave_display_idle;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;
  logic [1:0]  capture_state;

  // capture block side
  modport master (
    input  new_sample_ready,
    input  new_sample_in,
    input  wave_display_idle,
    output write_address,
    output write_enable,
    output write_sample,
    output read_index,
    output capture_state
  );

  // sample source / display / RAM side
  modport slave (
    output new_sample_ready,
    output new_sample_in,
    output wave_display_idle,
    input  write_address,
    input  write_enable,
    input  write_sample,
    input  read_index,
    input  capture_state
  );
endinterface

// File: rtl/wave_capture.sv
// rtl/wave_capture.sv - zero-crossing triggered capture into the idle half of a double-buffered sample RAM
module wave_capture #(
  parameter int unsigned AUTO_TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           reset_n,
  wave_capture_if.master bus
);

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam bit          TIMEOUT_EN   = (AUTO_TIMEOUT != 0);
  localparam logic [15:0] TIMEOUT_LAST = 16'(AUTO_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  offset_q, offset_d;
  logic [15:0] timeout_q, timeout_d;
  logic [15:0] prev_q;
  logic        read_index_q, read_index_d;
  logic        we_q, we_d;
  logic [8:0]  wa_q, wa_d;
  logic [7:0]  ws_q, ws_d;

  logic        strobe;
  logic        crossing;
  logic        forced;
  logic [7:0]  conv;

  assign strobe   = bus.new_sample_ready;
  assign crossing = prev_q[15] & ~bus.new_sample_in[15];
  assign forced   = TIMEOUT_EN && (timeout_q == TIMEOUT_LAST);
  // 127 - s for the top byte: flipping the low seven bits maps +127 to the top line
  assign conv     = {bus.new_sample_in[15], ~bus.new_sample_in[14:8]};

  // previous sample tracks every strobe regardless of state so crossings are seen right after re-arming
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= '0;
    end else if (strobe) begin
      prev_q <= bus.new_sample_in;
    end
  end

  // state, counters and registered RAM write port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARMED;
      offset_q     <= '0;
      timeout_q    <= '0;
      read_index_q <= 1'b0;
      we_q         <= 1'b0;
      wa_q         <= '0;
      ws_q         <= '0;
    end else begin
      state_q      <= state_d;
      offset_q     <= offset_d;
      timeout_q    <= timeout_d;
      read_index_q <= read_index_d;
      we_q         <= we_d;
      wa_q         <= wa_d;
      ws_q         <= ws_d;
    end
  end

  // next-state: trigger in ARMED, fill 256 slots in ACTIVE, swap halves once the display is idle
  always_comb begin
    state_d      = state_q;
    offset_d     = offset_q;
    timeout_d    = timeout_q;
    read_index_d = read_index_q;
    we_d         = 1'b0;
    wa_d         = wa_q;
    ws_d         = ws_q;
    case (state_q)
      ARMED: begin
        if (strobe) begin
          if (crossing || forced) begin
            we_d     = 1'b1;
            wa_d     = {~read_index_q, 8'd0};
            ws_d     = conv;
            offset_d = 8'd1;
            state_d  = ACTIVE;
          end else begin
            timeout_d = timeout_q + 16'd1;
          end
        end
      end
      ACTIVE: begin
        if (strobe) begin
          we_d     = 1'b1;
          wa_d     = {~read_index_q, offset_q};
          ws_d     = conv;
          offset_d = offset_q + 8'd1;
          if (offset_q == 8'hFF) begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // the swap is the only action here; a coincident strobe is not written
        if (bus.wave_display_idle) begin
          read_index_d = ~read_index_q;
          timeout_d    = '0;
          offset_d     = '0;
          state_d      = ARMED;
        end
      end
      default: begin
        state_d = ARMED;
      end
    endcase
  end

  assign bus.write_enable  = we_q;
  assign bus.write_address = wa_q;
  assign bus.write_sample  = ws_q;
  assign bus.read_index    = read_index_q;
  assign bus.capture_state = state_q;

endmodule

// File: tb/tb_wave_capture.sv
// tb/tb_wave_capture.sv - self-checking bench for wave_capture with three timeout settings
module tb_wave_capture;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rdy = 1'b0;
  logic [15:0] smp = '0;
  logic        idle = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wave_capture_if if_main ();
  wave_capture_if if_t4 ();
  wave_capture_if if_t0 ();

  assign if_main.new_sample_ready  = rdy;
  assign if_main.new_sample_in     = smp;
  assign if_main.wave_display_idle = idle;
  assign if_t4.new_sample_ready    = rdy;
  assign if_t4.new_sample_in       = smp;
  assign if_t4.wave_display_idle   = idle;
  assign if_t0.new_sample_ready    = rdy;
  assign if_t0.new_sample_in       = smp;
  assign if_t0.wave_display_idle   = idle;

  wave_capture #(.AUTO_TIMEOUT(1024)) u_main (.clk(clk), .reset_n(reset_n), .bus(if_main));
  wave_capture #(.AUTO_TIMEOUT(4))    u_t4   (.clk(clk), .reset_n(reset_n), .bus(if_t4));
  wave_capture #(.AUTO_TIMEOUT(0))    u_t0   (.clk(clk), .reset_n(reset_n), .bus(if_t0));

  // reference model: mode 0 waiting for trigger, 1 filling, 2 holding full buffer
  int to_val [3] = '{1024, 4, 0};
  int m_mode [3];
  int m_cnt  [3];
  int m_tcnt [3];
  int m_prev [3];
  int m_ridx [3];
  int m_we   [3];
  int m_wa   [3];
  int m_ws   [3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_mode[k] = 0; m_cnt[k] = 0; m_tcnt[k] = 0; m_prev[k] = 0;
      m_ridx[k] = 0; m_we[k] = 0; m_wa[k] = 0; m_ws[k] = 0;
    end
  endtask

  task automatic model_step(int k);
    int sv;
    int s;
    bit trig;
    sv = int'($signed(smp));
    s  = sv >>> 8;
    m_we[k] = 0;
    if (m_mode[k] == 0) begin
      if (rdy) begin
        trig = (m_prev[k] < 0 && sv >= 0) || (to_val[k] != 0 && m_tcnt[k] == to_val[k] - 1);
        if (trig) begin
          m_we[k] = 1; m_wa[k] = (1 - m_ridx[k]) * 256; m_ws[k] = 127 - s;
          m_cnt[k] = 1; m_mode[k] = 1;
        end else begin
          m_tcnt[k] = (m_tcnt[k] + 1) % 65536;
        end
      end
    end else if (m_mode[k] == 1) begin
      if (rdy) begin
        m_we[k] = 1; m_wa[k] = (1 - m_ridx[k]) * 256 + m_cnt[k]; m_ws[k] = 127 - s;
        m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] == 256) m_mode[k] = 2;
      end
    end else begin
      if (idle) begin
        m_ridx[k] = 1 - m_ridx[k]; m_mode[k] = 0; m_tcnt[k] = 0;
      end
    end
    if (rdy) m_prev[k] = sv;
  endtask

  task automatic cmp(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_dut(int k, logic we, logic [8:0] wa, logic [7:0] ws, logic ri, logic [1:0] st);
    cmp($sformatf("d%0d write_enable", k), int'(we), m_we[k]);
    if (m_we[k] != 0) begin
      cmp($sformatf("d%0d write_address", k), int'(wa), m_wa[k]);
      cmp($sformatf("d%0d write_sample", k), int'(ws), m_ws[k]);
    end
    cmp($sformatf("d%0d read_index", k), int'(ri), m_ridx[k]);
    cmp($sformatf("d%0d capture_state", k), int'(st), m_mode[k]);
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
    check_dut(0, if_main.write_enable, if_main.write_address, if_main.write_sample, if_main.read_index, if_main.capture_state);
    check_dut(1, if_t4.write_enable, if_t4.write_address, if_t4.write_sample, if_t4.read_index, if_t4.capture_state);
    check_dut(2, if_t0.write_enable, if_t0.write_address, if_t0.write_sample, if_t0.read_index, if_t0.capture_state);
  endtask

  task automatic check_reset_outputs(string tag);
    cmp({tag, " main we"}, int'(if_main.write_enable), 0);
    cmp({tag, " main wa"}, int'(if_main.write_address), 0);
    cmp({tag, " main ws"}, int'(if_main.write_sample), 0);
    cmp({tag, " main ri"}, int'(if_main.read_index), 0);
    cmp({tag, " main st"}, int'(if_main.capture_state), 0);
    cmp({tag, " t4 we"}, int'(if_t4.write_enable), 0);
    cmp({tag, " t4 ri"}, int'(if_t4.read_index), 0);
    cmp({tag, " t4 st"}, int'(if_t4.capture_state), 0);
  endtask

  typedef struct {
    logic        rdy;
    logic [15:0] smp;
    logic        idle;
    logic        we;
    logic [8:0]  wa;
    logic [7:0]  ws;
    logic [1:0]  st;
    logic        ri;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int n_wr;
    int last_wa;

    tbl[0] = '{1'b1, 16'hFF9C, 1'b0, 1'b0, 9'h000, 8'h00, 2'd0, 1'b0};
    tbl[1] = '{1'b1, 16'd50,   1'b0, 1'b1, 9'h100, 8'd127, 2'd1, 1'b0};
    tbl[2] = '{1'b1, 16'h7F00, 1'b0, 1'b1, 9'h101, 8'h00, 2'd1, 1'b0};
    tbl[3] = '{1'b1, 16'h0000, 1'b0, 1'b1, 9'h102, 8'h7F, 2'd1, 1'b0};
    tbl[4] = '{1'b1, 16'hFF00, 1'b0, 1'b1, 9'h103, 8'h80, 2'd1, 1'b0};
    tbl[5] = '{1'b1, 16'h8000, 1'b0, 1'b1, 9'h104, 8'hFF, 2'd1, 1'b0};
    tbl[6] = '{1'b0, 16'h1234, 1'b1, 1'b0, 9'h104, 8'hFF, 2'd1, 1'b0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    reset_n = 1'b1;

    // trigger on -100 -> +50 and conversion sweep
    n_wr = 0;
    for (int i = 0; i < 7; i++) begin
      rdy = tbl[i].rdy; smp = tbl[i].smp; idle = tbl[i].idle;
      tick();
      cmp($sformatf("tbl%0d we", i), int'(if_main.write_enable), int'(tbl[i].we));
      if (tbl[i].we) begin
        cmp($sformatf("tbl%0d wa", i), int'(if_main.write_address), int'(tbl[i].wa));
        cmp($sformatf("tbl%0d ws", i), int'(if_main.write_sample), int'(tbl[i].ws));
        n_wr++;
      end
      cmp($sformatf("tbl%0d st", i), int'(if_main.capture_state), int'(tbl[i].st));
      cmp($sformatf("tbl%0d ri", i), int'(if_main.read_index), int'(tbl[i].ri));
    end

    // finish the capture with a ramp
    idle = 1'b0;
    last_wa = 0;
    for (int i = 5; i < 256; i++) begin
      rdy = 1'b1; smp = 16'(i * 100);
      tick();
      if (if_main.write_enable) begin
        n_wr++;
        last_wa = int'(if_main.write_address);
      end
    end
    cmp("capture write count", n_wr, 256);
    cmp("capture last address", last_wa, 9'h1FF);
    cmp("state after capture", int'(if_main.capture_state), 2);
    smp = 16'd30000;
    tick();
    cmp("257th strobe we", int'(if_main.write_enable), 0);

    // long WAIT with the display busy
    n_wr = 0;
    for (int i = 0; i < 500; i++) begin
      rdy = ($urandom_range(0, 1) == 1); smp = 16'($urandom);
      tick();
      if (if_main.write_enable) n_wr++;
    end
    cmp("writes during wait", n_wr, 0);
    cmp("ri during wait", int'(if_main.read_index), 0);
    rdy = 1'b1; smp = 16'hFFFF; idle = 1'b1;
    tick();
    cmp("ri after swap", int'(if_main.read_index), 1);
    cmp("state after swap", int'(if_main.capture_state), 0);
    cmp("swap strobe not written", int'(if_main.write_enable), 0);
    idle = 1'b0;

    // second capture goes to the lower half, aborted by reset at offset 100
    rdy = 1'b1; smp = 16'hEC78;
    tick();
    smp = 16'd5000;
    tick();
    cmp("second capture we", int'(if_main.write_enable), 1);
    cmp("second capture wa", int'(if_main.write_address), 9'h000);
    for (int i = 1; i <= 100; i++) begin
      smp = 16'(i * 50);
      tick();
    end
    cmp("offset 100 address", int'(if_main.write_address), 9'h064);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("midreset");
    rdy = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // forced trigger on the 4th non-crossing strobe
    for (int i = 1; i <= 4; i++) begin
      rdy = 1'b1; smp = 16'd1000;
      tick();
      cmp($sformatf("t4 strobe%0d we", i), int'(if_t4.write_enable), (i == 4) ? 1 : 0);
    end
    cmp("t4 forced wa", int'(if_t4.write_address), 9'h100);
    cmp("t4 forced ws", int'(if_t4.write_sample), 124);
    n_wr = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (if_t0.write_enable) n_wr++;
    end
    cmp("t0 no writes", n_wr, 0);
    cmp("t0 still armed", int'(if_t0.capture_state), 0);
    smp = 16'hFFFF;
    tick();
    smp = 16'd1;
    tick();
    cmp("post-reset crossing we", int'(if_main.write_enable), 1);
    cmp("post-reset crossing wa", int'(if_main.write_address), 9'h100);

    // randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      rdy  = ($urandom_range(0, 3) != 0);
      smp  = 16'($urandom);
      idle = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wave_capture.md
# wave_capture

Capture stage directly upstream of the waveform display. Watches the 16-bit signed audio sample stream, arms on a negative-to-non-negative zero crossing, and writes 256 consecutive samples, converted to 8-bit screen-oriented values, into the half of the 512-entry dual-port sample RAM that the display is not reading. When the display reports it is idle, it flips `read_index` so the display switches to the freshly captured half. It then re-arms.

## Interface
Parameters:
- AUTO_TIMEOUT, 1024: strobes spent in ARMED without a crossing before a forced trigger. 0 disables forced triggering. Legal range 0..65535.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- new_sample_ready  in  1  one-cycle strobe; new_sample_in valid this cycle
- new_sample_in  in  16  signed two's-complement audio sample
- wave_display_idle  in  1  high while the display is outside its drawing window (safe to swap halves)
- write_address  out  9  RAM write address {~read_index, offset[7:0]}
- write_enable  out  1  RAM write strobe, one cycle per written sample
- write_sample  out  8  converted sample data
- read_index  out  1  RAM half the display reads; capture writes the other half
- capture_state  out  2  debug: 0=ARMED, 1=ACTIVE, 2=WAIT

## Operation
- Conversion: s = new_sample_in[15:8]. write_sample = {s[7], ~s[6:0]}, which equals 127 − s. Examples: +127→0 (top of screen), 0→127, −1→128, −128→255.
- prev_sample register: holds the last strobed new_sample_in. Updated on every strobe in every state. Reset value is 0.
- Crossing: a strobe where prev_sample[15]=1 and new_sample_in[15]=0.
- FSM:
  - ARMED: on a strobe with a crossing, write the triggering sample at offset 0, set offset to 1, and go to ACTIVE. Otherwise, on a strobe, increment timeout_cnt. If AUTO_TIMEOUT≠0 and timeout_cnt==AUTO_TIMEOUT−1 at a strobe, that strobe is a forced trigger and is handled identically to a crossing. timeout_cnt (16 bit) clears on entering ARMED and on reset.
  - ACTIVE: each strobe writes at the current offset, then offset increments. The write at offset 255 moves the FSM to WAIT. Offset is 8-bit and is not allowed to wrap during a capture.
  - WAIT: no writes. On the first cycle with wave_display_idle=1, toggle read_index and go to ARMED.
- Strobes in WAIT are dropped, except for the prev_sample update.
- wave_display_idle is ignored in ARMED and ACTIVE.
- A strobe and wave_display_idle arriving in the same cycle in WAIT: swap happens and the sample is not written. That strobe still updates prev_sample, but does not count toward timeout.
- The write half is always ~read_index. The display never sees a partially written half.

## Timing
- Reset (async assert, sync release): capture_state=ARMED, read_index=0, write_enable=0, write_address=0, write_sample=0, offset=0, timeout_cnt=0, prev_sample=0.
- write_enable, write_address and write_sample are registered. They are valid the cycle after the accepted strobe. write_enable is high for exactly one cycle per written sample.
- read_index toggles on the clock edge that samples wave_display_idle=1 in WAIT. capture_state reads ARMED in the cycle after that edge.
- Back-to-back strobes on consecutive cycles are supported. Throughput is one sample per cycle.
- Reset asserted mid-capture aborts immediately. Partially written RAM contents are abandoned. read_index returns to 0.
- A capture takes at least 256 strobes, plus the WAIT duration.

## Test plan
- Reset, then drive strobes −100, +50 → first write one cycle later: write_enable=1, write_address=0x100, write_sample=127−0=127 (+50 has s=0). capture_state=ACTIVE.
- Full capture of 256 ramp samples after a trigger → exactly 256 writes at addresses 0x100..0x1FF, then capture_state=WAIT. A 257th strobe produces no write.
- In WAIT, hold wave_display_idle=0 for 500 cycles with strobes → no writes and read_index stays 0. Raise idle → read_index=1 next cycle. The next capture writes 0x000..0x0FF.
- AUTO_TIMEOUT=4 with constant +1000 samples → forced trigger on the 4th strobe, which is written at offset 0 with write_sample=127−3=124. With AUTO_TIMEOUT=0 and the same stimulus, the block stays in ARMED indefinitely.
- Conversion sweep of s = 0x7F, 0x00, 0xFF, 0x80 → write_sample 0x00, 0x7F, 0x80, 0xFF.
- reset_n pulsed low at offset 100 (asynchronous, mid-cycle) → all outputs go to their reset values immediately. After release, a new crossing writes starting at 0x100.
